// File: rtl/traffic_generator_axis.sv
// traffic_generator_axis
//   AXI4-Stream frame generator for link test traffic. Produces frames of a
//   programmable byte length separated by a programmable idle gap, either as a
//   counted burst or continuously until stopped.
//
//   Optional feature macro: TRAFFIC_GEN_PRBS_EN
//     defined   : payload mode 10 emits PRBS31 (x^31+x^28+1), reseeded per frame
//     undefined : no LFSR is built; mode 10 behaves as mode 00
//
// Ports
//   axis_aclk, axis_resetn   clock, asynchronous active-low reset
//   cfg_start / cfg_stop     run control pulses
//   cfg_frame_size           frame length in bytes (0 treated as 1)
//   cfg_ifg                  idle cycles between frames (0 treated as 1)
//   cfg_frame_count          frames per run, 0 = continuous
//   cfg_mode, cfg_pattern    payload selection (00/11 incrementing, 01 fixed, 10 PRBS31)
//   m_axis_*                 master stream (tdata, tkeep, tvalid, tready, tlast)
//   stat_busy                high while not IDLE
//   stat_done                one-cycle pulse when a run returns to IDLE
//   stat_frames_sent         frames completed since the last start
module traffic_generator_axis #(
   parameter int C_M_AXIS_DATA_WIDTH = 64,
   parameter int C_CNT_WIDTH         = 32
) (
   input  logic                             axis_aclk,
   input  logic                             axis_resetn,
   input  logic                             cfg_start,
   input  logic                             cfg_stop,
   input  logic [15:0]                      cfg_frame_size,
   input  logic [15:0]                      cfg_ifg,
   input  logic [C_CNT_WIDTH-1:0]           cfg_frame_count,
   input  logic [1:0]                       cfg_mode,
   input  logic [7:0]                       cfg_pattern,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic                             stat_busy,
   output logic                             stat_done,
   output logic [C_CNT_WIDTH-1:0]           stat_frames_sent
);

   localparam int W     = C_M_AXIS_DATA_WIDTH;
   localparam int BYTES = C_M_AXIS_DATA_WIDTH / 8;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_GAP} state_t;

   state_t                 state_reg, state_next;
   logic [15:0]            size_reg;
   logic [15:0]            ifg_reg;
   logic [C_CNT_WIDTH-1:0] count_reg;
   logic [1:0]             mode_reg;
   logic [7:0]             pattern_reg;
   logic                   stop_pend_reg;
   logic [15:0]            gap_cnt_reg;
   logic [15:0]            offset_reg;
   logic [C_CNT_WIDTH-1:0] frames_reg;
   logic                   done_reg;
   logic [W-1:0]           tdata_reg;
   logic [BYTES-1:0]       tkeep_reg;
   logic                   tlast_reg;
   logic                   tvalid_reg;

   logic                   start_ok;
   logic                   handshake;
   logic                   last_hs;
   logic                   stop_eff;
   logic                   finish;
   logic [C_CNT_WIDTH-1:0] frames_inc;
   logic [15:0]            cfg_size_eff;
   logic [15:0]            cfg_ifg_eff;
   logic [1:0]             cfg_mode_norm;

   logic                   load_first;
   logic                   load_next;
   logic [15:0]            sel_size;
   logic [1:0]             sel_mode;
   logic [7:0]             sel_pattern;
   logic [15:0]            sel_offset;
   logic [W-1:0]           beat_data;
   logic [BYTES-1:0]       beat_keep;
   logic                   beat_last;

   // Collapse the mode encoding once at start so the datapath only ever sees
   // 00 (incrementing), 01 (fixed) and, when built in, 10 (PRBS).
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
`ifdef TRAFFIC_GEN_PRBS_EN
      return (m == 2'b11) ? 2'b00 : m;
`else
      return (m == 2'b01) ? 2'b01 : 2'b00;
`endif
   endfunction

   assign cfg_size_eff  = (cfg_frame_size == 16'd0) ? 16'd1 : cfg_frame_size;
   assign cfg_ifg_eff   = (cfg_ifg == 16'd0) ? 16'd1 : cfg_ifg;
   assign cfg_mode_norm = norm_mode(cfg_mode);

   // A simultaneous stop suppresses the start.
   assign start_ok   = (state_reg == ST_IDLE) && cfg_start && !cfg_stop;
   assign handshake  = tvalid_reg && m_axis_tready;
   assign last_hs    = handshake && tlast_reg;
   assign stop_eff   = stop_pend_reg || cfg_stop;
   assign frames_inc = frames_reg + 1'b1;
   assign finish     = stop_eff || ((count_reg != '0) && (frames_inc == count_reg));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start_ok) state_next = ST_DATA;
         ST_DATA: if (last_hs) state_next = finish ? ST_IDLE : ST_GAP;
         ST_GAP: begin
            if (stop_eff) state_next = ST_IDLE;
            else if (gap_cnt_reg == 16'd1) state_next = ST_DATA;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / beat selection ----------------
   // Frame start uses the live config on a start, the latched config after a gap.
   always_comb begin
      load_first  = start_ok ||
                    ((state_reg == ST_GAP) && !stop_eff && (gap_cnt_reg == 16'd1));
      load_next   = (state_reg == ST_DATA) && handshake && !tlast_reg;
      sel_size    = start_ok ? cfg_size_eff  : size_reg;
      sel_mode    = start_ok ? cfg_mode_norm : mode_reg;
      sel_pattern = start_ok ? cfg_pattern   : pattern_reg;
      sel_offset  = load_first ? 16'd0 : (offset_reg + 16'(BYTES));
   end

   assign beat_last = (({1'b0, sel_size} - {1'b0, sel_offset}) <= 17'(BYTES));

`ifdef TRAFFIC_GEN_PRBS_EN
   localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

   logic [30:0]  prbs_reg;
   logic [30:0]  prbs_adv;
   logic [W-1:0] prbs_bits;

   // Advance the LFSR W steps; the first generated bit lands in bit 0.
   always_comb begin
      logic [30:0] s;
      logic        nb;
      s         = load_first ? PRBS_SEED : prbs_reg;
      nb        = 1'b0;
      prbs_bits = '0;
      for (int b = 0; b < W; b++) begin
         nb           = s[30] ^ s[27];
         prbs_bits[b] = nb;
         s            = {s[29:0], nb};
      end
      prbs_adv = s;
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         prbs_reg <= '0;
      end else if (load_first || load_next) begin
         prbs_reg <= prbs_adv;
      end
   end
`endif

   // Per-lane payload: byte lanes beyond the frame end are zero and unkept.
   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
         logic [16:0] idx;
         logic        in_frame;
         logic [7:0]  val;

         assign idx      = {1'b0, sel_offset} + 17'(gi);
         assign in_frame = (idx < {1'b0, sel_size});

         always_comb begin
            case (sel_mode)
               2'b01:   val = sel_pattern;
`ifdef TRAFFIC_GEN_PRBS_EN
               2'b10:   val = prbs_bits[gi*8 +: 8];
`endif
               default: val = idx[7:0] + 8'd1;
            endcase
         end

         assign beat_data[gi*8 +: 8] = in_frame ? val : 8'h00;
         assign beat_keep[gi]        = in_frame;
      end
   endgenerate

   // ---------------- datapath registers ----------------
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         size_reg      <= '0;
         ifg_reg       <= '0;
         count_reg     <= '0;
         mode_reg      <= '0;
         pattern_reg   <= '0;
         stop_pend_reg <= 1'b0;
         gap_cnt_reg   <= '0;
         offset_reg    <= '0;
         frames_reg    <= '0;
         done_reg      <= 1'b0;
         tdata_reg     <= '0;
         tkeep_reg     <= '0;
         tlast_reg     <= 1'b0;
         tvalid_reg    <= 1'b0;
      end else begin
         done_reg <= (state_reg != ST_IDLE) && (state_next == ST_IDLE);

         if (start_ok) begin
            size_reg    <= cfg_size_eff;
            ifg_reg     <= cfg_ifg_eff;
            count_reg   <= cfg_frame_count;
            mode_reg    <= cfg_mode_norm;
            pattern_reg <= cfg_pattern;
            frames_reg  <= '0;
         end

         if (state_next == ST_IDLE) begin
            stop_pend_reg <= 1'b0;
         end else if (cfg_stop && (state_reg != ST_IDLE)) begin
            stop_pend_reg <= 1'b1;
         end

         if (load_first || load_next) begin
            tdata_reg  <= beat_data;
            tkeep_reg  <= beat_keep;
            tlast_reg  <= beat_last;
            tvalid_reg <= 1'b1;
            offset_reg <= sel_offset;
         end else if (last_hs) begin
            tdata_reg  <= '0;
            tkeep_reg  <= '0;
            tlast_reg  <= 1'b0;
            tvalid_reg <= 1'b0;
         end

         if (last_hs) begin
            frames_reg  <= frames_inc;
            gap_cnt_reg <= ifg_reg;
         end else if (state_reg == ST_GAP) begin
            gap_cnt_reg <= gap_cnt_reg - 16'd1;
         end
      end
   end

   assign m_axis_tdata     = tdata_reg;
   assign m_axis_tkeep     = tkeep_reg;
   assign m_axis_tvalid    = tvalid_reg;
   assign m_axis_tlast     = tlast_reg;
   assign stat_busy        = (state_reg != ST_IDLE);
   assign stat_done        = done_reg;
   assign stat_frames_sent = frames_reg;

endmodule

// File: tb/tb_traffic_generator_axis.sv
// Testbench for traffic_generator_axis (64-bit stream). Table of single-frame
// vectors plus hand-written sequences for backpressure, continuous run with
// stop, counted bursts, reset mid-frame and (when built in) PRBS31 payload.
module tb_traffic_generator_axis;

   localparam int W     = 64;
   localparam int BYTES = 8;
   localparam int CW    = 32;

   logic          clk = 1'b0;
   logic          resetn;
   logic          cfg_start, cfg_stop;
   logic [15:0]   cfg_frame_size, cfg_ifg;
   logic [CW-1:0] cfg_frame_count;
   logic [1:0]    cfg_mode;
   logic [7:0]    cfg_pattern;
   logic [W-1:0]  m_axis_tdata;
   logic [7:0]    m_axis_tkeep;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic          stat_busy, stat_done;
   logic [CW-1:0] stat_frames_sent;

   always #5 clk = ~clk;

   traffic_generator_axis #(.C_M_AXIS_DATA_WIDTH(W), .C_CNT_WIDTH(CW)) dut (
      .axis_aclk(clk), .axis_resetn(resetn),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_frame_size(cfg_frame_size), .cfg_ifg(cfg_ifg),
      .cfg_frame_count(cfg_frame_count), .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .stat_busy(stat_busy), .stat_done(stat_done), .stat_frames_sent(stat_frames_sent)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- collected run results ----------------
   logic [7:0]  byte_q[$];
   int          beats_q[$];
   int          flen_q[$];
   logic [63:0] first_beat0;
   logic [7:0]  last_keep;
   int          done_cnt, stall_err, pad_err, gap_min, gap_max, hs_total;
   int          first_valid_cyc;
   bit          timeout;

   task automatic start_run(input logic [15:0] size, input logic [15:0] ifg,
                            input logic [CW-1:0] count, input logic [1:0] mode,
                            input logic [7:0] pat);
      @(negedge clk);
      cfg_frame_size  = size;
      cfg_ifg         = ifg;
      cfg_frame_count = count;
      cfg_mode        = mode;
      cfg_pattern     = pat;
      cfg_stop        = 1'b0;
      cfg_start       = 1'b1;
      m_axis_tready   = 1'b1;
   endtask

   // Observe the stream at negedges until the generator returns to IDLE.
   task automatic collect(input int max_cycles, input bit toggle, input int stop_at,
                          input int start_at);
      int          cyc = 0;
      int          beats = 0;
      int          flen = 0;
      int          gap = 0;
      bit          in_gap = 0;
      bit          ready = 1;
      bit          stalled = 0;
      bit          seen = 0;
      bit          stop_done = 0;
      bit          start_done = 0;
      logic [63:0] hold_d;
      logic [7:0]  hold_k;
      logic        hold_l;
      byte_q.delete(); beats_q.delete(); flen_q.delete();
      first_beat0 = '0; last_keep = '0;
      done_cnt = 0; stall_err = 0; pad_err = 0; hs_total = 0;
      gap_min = 1000000; gap_max = -1; first_valid_cyc = -1; timeout = 0;
      hold_d = '0; hold_k = '0; hold_l = 1'b0;
      while (1) begin
         @(negedge clk);
         cyc++;
         cfg_start = 1'b0;
         cfg_stop  = 1'b0;
         if (cyc == 1) begin
            // Scramble config: a busy generator must ignore it.
            cfg_frame_size = 16'd5; cfg_ifg = 16'd50; cfg_frame_count = 32'd0;
            cfg_mode = 2'b01; cfg_pattern = 8'h77;
         end
         if (stat_done) done_cnt++;
         if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (stalled && (m_axis_tdata !== hold_d || m_axis_tkeep !== hold_k ||
                         m_axis_tlast !== hold_l || m_axis_tvalid !== 1'b1))
            stall_err++;
         if (!m_axis_tvalid) begin
            if (in_gap) gap++;
         end else if (in_gap) begin
            in_gap = 0;
            if (gap < gap_min) gap_min = gap;
            if (gap > gap_max) gap_max = gap;
         end
         if (stat_busy) seen = 1;
         else if (seen) break;
         if (cyc > max_cycles) begin
            timeout = 1;
            break;
         end
         ready = toggle ? ~ready : 1'b1;
         m_axis_tready = ready;
         if (!stop_done && stop_at >= 0 && hs_total == stop_at) begin
            cfg_stop = 1'b1; stop_done = 1;
         end
         if (!start_done && start_at >= 0 && hs_total == start_at) begin
            cfg_start = 1'b1; start_done = 1;
         end
         if (m_axis_tvalid && ready) begin
            if (beats == 0 && beats_q.size() == 0) first_beat0 = m_axis_tdata;
            for (int j = 0; j < BYTES; j++) begin
               if (m_axis_tkeep[j]) byte_q.push_back(m_axis_tdata[j*8 +: 8]);
               else if (m_axis_tdata[j*8 +: 8] !== 8'h00) pad_err++;
            end
            beats++;
            flen += $countones(m_axis_tkeep);
            hs_total++;
            if (m_axis_tlast) begin
               beats_q.push_back(beats);
               flen_q.push_back(flen);
               last_keep = m_axis_tkeep;
               beats = 0; flen = 0; in_gap = 1; gap = 0;
            end
            stalled = 0;
         end else if (m_axis_tvalid) begin
            stalled = 1;
            hold_d = m_axis_tdata; hold_k = m_axis_tkeep; hold_l = m_axis_tlast;
         end else begin
            stalled = 0;
         end
      end
   endtask

   function automatic logic [7:0] exp_byte(input logic [1:0] mode, input logic [7:0] pat,
                                           input int i);
      if (mode == 2'b01) return pat;
      return 8'((i + 1) % 256);
   endfunction

   function automatic int byte_errs(input int flen, input logic [1:0] mode,
                                    input logic [7:0] pat);
      int e = 0;
      for (int k = 0; k < byte_q.size(); k++)
         if (byte_q[k] !== exp_byte(mode, pat, k % flen)) e++;
      return e;
   endfunction

   function automatic int all_equal(input int q[$], input int v);
      int e = 0;
      foreach (q[k]) if (q[k] != v) e++;
      return e;
   endfunction

`ifdef TRAFFIC_GEN_PRBS_EN
   function automatic logic [63:0] prbs_model(inout logic [30:0] s);
      logic [63:0] d;
      logic        nb;
      d = '0;
      for (int b = 0; b < 64; b++) begin
         nb   = s[30] ^ s[27];
         d[b] = nb;
         s    = {s[29:0], nb};
      end
      return d;
   endfunction
`endif

   typedef struct {
      logic [15:0] size;
      logic [1:0]  mode;
      logic [7:0]  pat;
      int          beats;
      logic [7:0]  keep;
      logic [63:0] beat0;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vecs.push_back('{16'd60,  2'b00, 8'h00, 8,  8'h0F, 64'h0807060504030201});
      vecs.push_back('{16'd64,  2'b00, 8'h00, 8,  8'hFF, 64'h0807060504030201});
      vecs.push_back('{16'd1,   2'b00, 8'h00, 1,  8'h01, 64'h0000000000000001});
      vecs.push_back('{16'd0,   2'b00, 8'h00, 1,  8'h01, 64'h0000000000000001});
      vecs.push_back('{16'd13,  2'b01, 8'hA5, 2,  8'h1F, 64'hA5A5A5A5A5A5A5A5});
      vecs.push_back('{16'd9,   2'b11, 8'h00, 2,  8'h01, 64'h0807060504030201});
      vecs.push_back('{16'd300, 2'b00, 8'h00, 38, 8'h0F, 64'h0807060504030201});
`ifndef TRAFFIC_GEN_PRBS_EN
      vecs.push_back('{16'd8,   2'b10, 8'h00, 1,  8'hFF, 64'h0807060504030201});
`endif

      resetn = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
      cfg_frame_size = '0; cfg_ifg = '0; cfg_frame_count = '0;
      cfg_mode = '0; cfg_pattern = '0; m_axis_tready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      check("reset_tdata", m_axis_tdata, 64'd0);
      check("reset_tkeep_tlast", {55'd0, m_axis_tkeep, m_axis_tlast}, 64'd0);
      check("reset_busy_done", {62'd0, stat_busy, stat_done}, 64'd0);
      check("reset_frames", {32'd0, stat_frames_sent}, 64'd0);
      resetn = 1'b1;

      // ---- table-driven single-frame vectors ----
      foreach (vecs[v]) begin
         int flen;
         flen = (vecs[v].size == 16'd0) ? 1 : int'(vecs[v].size);
         start_run(vecs[v].size, 16'd12, 32'd1, vecs[v].mode, vecs[v].pat);
         collect(2000, 0, -1, -1);
         $display("vector %0d: size=%0d mode=%0d frames=%0d beats=%0d keep=0x%0h beat0=0x%0h",
                  v, vecs[v].size, vecs[v].mode, beats_q.size(),
                  (beats_q.size() > 0) ? beats_q[0] : -1, last_keep, first_beat0);
         check($sformatf("v%0d_timeout", v), 64'(timeout), 64'd0);
         check($sformatf("v%0d_latency", v), 64'(first_valid_cyc), 64'd1);
         check($sformatf("v%0d_frames", v), 64'(beats_q.size()), 64'd1);
         check($sformatf("v%0d_beats", v), 64'((beats_q.size() > 0) ? beats_q[0] : -1),
               64'(vecs[v].beats));
         check($sformatf("v%0d_last_keep", v), 64'(last_keep), 64'(vecs[v].keep));
         check($sformatf("v%0d_beat0", v), first_beat0, vecs[v].beat0);
         check($sformatf("v%0d_len", v), 64'(byte_q.size()), 64'(flen));
         check($sformatf("v%0d_bytes", v), 64'(byte_errs(flen, vecs[v].mode, vecs[v].pat)), 64'd0);
         check($sformatf("v%0d_pad", v), 64'(pad_err), 64'd0);
         check($sformatf("v%0d_done", v), 64'(done_cnt), 64'd1);
         check($sformatf("v%0d_frames_sent", v), 64'(stat_frames_sent), 64'd1);
      end

      // ---- backpressure: tready toggling ----
      start_run(16'd60, 16'd12, 32'd1, 2'b00, 8'h00);
      collect(2000, 1, -1, -1);
      $display("stall: frames=%0d bytes=%0d stall_err=%0d", beats_q.size(), byte_q.size(), stall_err);
      check("stall_timeout", 64'(timeout), 64'd0);
      check("stall_stable", 64'(stall_err), 64'd0);
      check("stall_beats", 64'((beats_q.size() > 0) ? beats_q[0] : -1), 64'd8);
      check("stall_len", 64'(byte_q.size()), 64'd60);
      check("stall_bytes", 64'(byte_errs(60, 2'b00, 8'h00)), 64'd0);
      check("stall_done", 64'(done_cnt), 64'd1);

      // ---- continuous run, stop mid third frame ----
      start_run(16'd20, 16'd3, 32'd0, 2'b00, 8'h00);
      collect(2000, 0, 7, -1);
      $display("continuous: frames=%0d gap_min=%0d gap_max=%0d done=%0d", beats_q.size(),
               gap_min, gap_max, done_cnt);
      check("cont_timeout", 64'(timeout), 64'd0);
      check("cont_frames", 64'(beats_q.size()), 64'd3);
      check("cont_beats", 64'(all_equal(beats_q, 3)), 64'd0);
      check("cont_gap_min", 64'(gap_min), 64'd3);
      check("cont_gap_max", 64'(gap_max), 64'd3);
      check("cont_bytes", 64'(byte_errs(20, 2'b00, 8'h00)), 64'd0);
      check("cont_done", 64'(done_cnt), 64'd1);
      check("cont_frames_sent", 64'(stat_frames_sent), 64'd3);

      // ---- stop while in the gap ----
      start_run(16'd20, 16'd3, 32'd0, 2'b00, 8'h00);
      collect(2000, 0, 3, -1);
      $display("gap stop: frames=%0d done=%0d", beats_q.size(), done_cnt);
      check("gstop_timeout", 64'(timeout), 64'd0);
      check("gstop_frames", 64'(beats_q.size()), 64'd1);
      check("gstop_done", 64'(done_cnt), 64'd1);
      check("gstop_frames_sent", 64'(stat_frames_sent), 64'd1);

      // ---- counted burst, ifg 0, start while busy ----
      start_run(16'd10, 16'd0, 32'd3, 2'b00, 8'h00);
      collect(2000, 0, -1, 3);
      $display("burst: frames=%0d gap_min=%0d gap_max=%0d done=%0d sent=%0d", beats_q.size(),
               gap_min, gap_max, done_cnt, stat_frames_sent);
      check("burst_timeout", 64'(timeout), 64'd0);
      check("burst_frames", 64'(beats_q.size()), 64'd3);
      check("burst_beats", 64'(all_equal(beats_q, 2)), 64'd0);
      check("burst_keep", 64'(last_keep), 64'h03);
      check("burst_gap_min", 64'(gap_min), 64'd1);
      check("burst_gap_max", 64'(gap_max), 64'd1);
      check("burst_done", 64'(done_cnt), 64'd1);
      check("burst_frames_sent", 64'(stat_frames_sent), 64'd3);
      check("burst_bytes", 64'(byte_errs(10, 2'b00, 8'h00)), 64'd0);

      // ---- reset asserted mid-frame ----
      start_run(16'd300, 16'd4, 32'd1, 2'b00, 8'h00);
      @(negedge clk); cfg_start = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_pre_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
      #2 resetn = 1'b0;
      #1;
      $display("reset mid-frame: tvalid=%0b tlast=%0b busy=%0b", m_axis_tvalid, m_axis_tlast, stat_busy);
      check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      check("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
      check("rst_busy", {63'd0, stat_busy}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      start_run(16'd60, 16'd4, 32'd1, 2'b00, 8'h00);
      collect(2000, 0, -1, -1);
      $display("after reset: frames=%0d beat0=0x%0h", beats_q.size(), first_beat0);
      check("rst_timeout", 64'(timeout), 64'd0);
      check("rst_beat0", first_beat0, 64'h0807060504030201);
      check("rst_bytes", 64'(byte_errs(60, 2'b00, 8'h00)), 64'd0);
      check("rst_len", 64'(byte_q.size()), 64'd60);

`ifdef TRAFFIC_GEN_PRBS_EN
      begin
         logic [30:0] s;
         logic [63:0] b0, b1;
         logic [7:0]  eb[16];
         int          e;
         s  = 31'h7FFF_FFFF;
         b0 = prbs_model(s);
         b1 = prbs_model(s);
         for (int k = 0; k < 16; k++) eb[k] = (k < 8) ? b0[k*8 +: 8] : b1[(k-8)*8 +: 8];
         start_run(16'd16, 16'd2, 32'd2, 2'b10, 8'h00);
         collect(2000, 0, -1, -1);
         e = 0;
         for (int k = 0; k < byte_q.size(); k++) if (byte_q[k] !== eb[k % 16]) e++;
         $display("prbs: frames=%0d beat0=0x%0h", beats_q.size(), first_beat0);
         check("prbs_timeout", 64'(timeout), 64'd0);
         check("prbs_beat0", first_beat0, b0);
         check("prbs_frames", 64'(beats_q.size()), 64'd2);
         check("prbs_len", 64'(byte_q.size()), 64'd32);
         check("prbs_bytes", 64'(e), 64'd0);
      end
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
